// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN front-end blocks.
package cnn_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned KSIZE  = 3;

    // Flat element index of window position (i, j).
    function automatic int unsigned idx(input int unsigned i, input int unsigned j);
        return KSIZE * i + j;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Fixed DEPTH-beat delay line, advancing only when en is high.
module line_delay #(
    parameter int unsigned DEPTH  = 13,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    import cnn_pkg::*;

    if (DEPTH > 32) begin : g_ram
        localparam int unsigned PW = cnt_w(DEPTH);

        logic [DATA_W-1:0] mem [DEPTH];
        logic [PW-1:0]     ptr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q <= '0;
            end else if (en) begin
                ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            end
        end

        // Read-before-write at the same slot yields exactly DEPTH beats of delay.
        always_ff @(posedge clk) begin
            if (en) begin
                mem[ptr_q] <= din;
            end
        end

        assign dout = mem[ptr_q];
    end else begin : g_sr
        logic [DEPTH*DATA_W-1:0] sr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else if (en) begin
                sr_q <= {sr_q[(DEPTH-1)*DATA_W-1:0], din};
            end
        end

        assign dout = sr_q[DEPTH*DATA_W-1 -: DATA_W];
    end

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 valid-convolution window generator with two internal line buffers.
module conv_window_3x3 #(
    parameter int unsigned IMG_W  = 13,
    parameter int unsigned IMG_H  = 13,
    parameter int unsigned DATA_W = cnn_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   pixel_in,
    input  logic                in_sof,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] window,
    output logic                out_last
);
    import cnn_pkg::*;

    localparam int unsigned CW = cnt_w(IMG_W);
    localparam int unsigned RW = cnt_w(IMG_H);

    logic [CW-1:0]       col_q, col_cur;
    logic [RW-1:0]       row_q, row_cur;
    logic                accept, emit, col_wrap, row_wrap;
    logic [DATA_W-1:0]   lb1_out, lb2_out;
    logic [DATA_W-1:0]   col_new [KSIZE];
    logic [DATA_W-1:0]   tap_q   [KSIZE][KSIZE-1];
    logic [9*DATA_W-1:0] window_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // in_sof resyncs the position of the pixel it arrives with.
    assign col_cur  = in_sof ? '0 : col_q;
    assign row_cur  = in_sof ? '0 : row_q;
    assign col_wrap = (col_cur == CW'(IMG_W - 1));
    assign row_wrap = (row_cur == RW'(IMG_H - 1));
    assign emit     = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            col_q <= col_wrap ? '0 : col_cur + 1'b1;
            if (col_wrap) begin
                row_q <= row_wrap ? '0 : row_cur + 1'b1;
            end else begin
                row_q <= row_cur;
            end
        end
    end

    line_delay #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .din  (pixel_in),
        .dout (lb1_out)
    );

    line_delay #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    assign col_new[0] = lb2_out;
    assign col_new[1] = lb1_out;
    assign col_new[2] = pixel_in;

    // The rightmost window column is the live input column, so the output
    // register can load on the same edge that accepts the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KSIZE; i++) begin
                tap_q[i][0] <= '0;
                tap_q[i][1] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < KSIZE; i++) begin
                tap_q[i][0] <= tap_q[i][1];
                tap_q[i][1] <= col_new[i];
            end
        end
    end

    always_comb begin
        window_d = '0;
        for (int i = 0; i < KSIZE; i++) begin
            window_d[DATA_W*idx(i, 0) +: DATA_W] = tap_q[i][0];
            window_d[DATA_W*idx(i, 1) +: DATA_W] = tap_q[i][1];
            window_d[DATA_W*idx(i, 2) +: DATA_W] = col_new[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            window    <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= row_wrap && col_wrap;
            window    <= window_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3: 4x4, 13x13 and 3x3 instances driven one at a time.
module tb_conv_window_3x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] pixel_in = '0;
    logic [1:0] sel = '0;

    logic [2:0]  iv, orr, ir, ov, ol;
    logic [71:0] win [3];
    logic        ir_s, ov_s, ol_s;
    logic [71:0] win_s;

    always #5 clk = ~clk;

    assign iv[0]  = in_valid && (sel == 2'd0);
    assign iv[1]  = in_valid && (sel == 2'd1);
    assign iv[2]  = in_valid && (sel == 2'd2);
    assign orr[0] = out_ready && (sel == 2'd0);
    assign orr[1] = out_ready && (sel == 2'd1);
    assign orr[2] = out_ready && (sel == 2'd2);

    always_comb begin
        ir_s  = ir[sel];
        ov_s  = ov[sel];
        ol_s  = ol[sel];
        win_s = win[sel];
    end

    conv_window_3x3 #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .pixel_in(pixel_in),
        .in_sof(in_sof), .out_valid(ov[0]), .out_ready(orr[0]), .window(win[0]),
        .out_last(ol[0])
    );

    conv_window_3x3 #(.IMG_W(13), .IMG_H(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .pixel_in(pixel_in),
        .in_sof(in_sof), .out_valid(ov[1]), .out_ready(orr[1]), .window(win[1]),
        .out_last(ol[1])
    );

    conv_window_3x3 #(.IMG_W(3), .IMG_H(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .pixel_in(pixel_in),
        .in_sof(in_sof), .out_valid(ov[2]), .out_ready(orr[2]), .window(win[2]),
        .out_last(ol[2])
    );

    typedef struct packed {
        logic [71:0] w;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_win = 0;
    int          n_last = 0;
    logic [71:0] first_win = '0;
    logic [71:0] last_win = '0;
    logic        last_flag = 1'b0;

    // Reference model: the frame as a plain image, position tracked by raster order.
    int          img_w = 4;
    int          img_h = 4;
    logic [7:0]  img [13][13];
    int          mrow = 0;
    int          mcol = 0;

    int          ready_mode = 0;
    int          stall_cnt = 0;
    bit          stall_armed = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] p, input bit sof, output bit emitted);
        exp_t e;
        emitted = 1'b0;
        if (sof) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = p;
        if (mrow >= 2 && mcol >= 2) begin
            e.w = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[8*(3*i+j) +: 8] = img[mrow-2+i][mcol-2+j];
            e.last = (mrow == img_h - 1) && (mcol == img_w - 1);
            q.push_back(e);
            emitted = 1'b1;
        end
        mcol++;
        if (mcol == img_w) begin
            mcol = 0;
            mrow = (mrow == img_h - 1) ? 0 : mrow + 1;
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input bit sof, input bit gaps);
        int  waitc = 0;
        bit  em;
        if (gaps) while ($urandom_range(0, 3) == 0) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        pixel_in = p;
        in_sof   = sof;
        #4;
        while (!ir_s) begin
            @(negedge clk);
            #4;
            waitc++;
            if (waitc > 500) begin
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "in_ready stuck low");
            end
        end
        model_accept(p, sof, em);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (em) chk("accept_to_valid_latency", 80'(ov_s), 80'(1));
    endtask

    task automatic start_test(input logic [1:0] s, input int w, input int h, input int mode);
        sel        = s;
        img_w      = w;
        img_h      = h;
        ready_mode = mode;
        n_win      = 0;
        n_last     = 0;
    endtask

    task automatic drain();
        int c = 0;
        while (q.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 80'(q.size()), 80'(0));
    endtask

    // Consumer: always ready, random, or a single 5-cycle stall on the first window.
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_cnt > 0) begin
                        out_ready = 1'b0;
                        stall_cnt--;
                    end else if (stall_armed && ov_s) begin
                        out_ready   = 1'b0;
                        stall_cnt   = 4;
                        stall_armed = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks holding on stalls.
    initial begin
        exp_t        e;
        bit          hold = 1'b0;
        logic [71:0] held_win;
        logic        held_last;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold)
                chk("stall_hold", {7'd0, ov_s, ol_s, win_s}, {7'd0, 1'b1, held_last, held_win});
            if (ov_s && !out_ready) begin
                chk("in_ready_during_stall", 80'(ir_s), 80'(0));
                hold      = 1'b1;
                held_win  = win_s;
                held_last = ol_s;
            end else begin
                hold = 1'b0;
            end
            if (ov_s && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got %0h expected none", win_s);
                end else begin
                    e = q.pop_front();
                    chk("window", 80'(win_s), 80'(e.w));
                    chk("out_last", 80'(ol_s), 80'(e.last));
                end
                n_win++;
                if (ol_s) n_last++;
                if (n_win == 1) first_win = win_s;
                last_win  = win_s;
                last_flag = ol_s;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #4;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk("reset_out_valid", 80'(ov_s), 80'(0));
            chk("reset_out_last", 80'(ol_s), 80'(0));
            chk("reset_window", 80'(win_s), 80'(0));
            chk("reset_in_ready", 80'(ir_s), 80'(1));
        end

        // 4x4 ramp, consumer always ready.
        start_test(2'd0, 4, 4, 0);
        for (int p = 0; p < 16; p++) send_pixel(8'(p), p == 0, 1'b0);
        drain();
        chk("t1_windows", 80'(n_win), 80'(4));
        chk("t1_lasts", 80'(n_last), 80'(1));
        chk("t1_first_window", 80'(first_win), 80'(72'h0a0908060504020100));
        chk("t1_last_window", 80'(last_win), 80'(72'h0f0e0d0b0a09070605));
        chk("t1_last_flag", 80'(last_flag), 80'(1));

        // Same ramp with a 5-cycle stall on the first window.
        start_test(2'd0, 4, 4, 2);
        stall_armed = 1'b1;
        for (int p = 0; p < 16; p++) send_pixel(8'(p), p == 0, 1'b0);
        drain();
        chk("t2_windows", 80'(n_win), 80'(4));
        chk("t2_first_window", 80'(first_win), 80'(72'h0a0908060504020100));

        // Three back-to-back random 13x13 frames with random handshakes.
        start_test(2'd1, 13, 13, 1);
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 169; p++)
                send_pixel(8'($urandom), (f == 0) && (p == 0), 1'b1);
        drain();
        chk("t3_windows", 80'(n_win), 80'(363));
        chk("t3_lasts", 80'(n_last), 80'(3));

        // Frame truncated by in_sof at its 7th pixel, then a full frame.
        start_test(2'd0, 4, 4, 1);
        for (int p = 0; p < 6; p++) send_pixel(8'($urandom), p == 0, 1'b1);
        for (int p = 0; p < 16; p++) send_pixel(8'($urandom), p == 0, 1'b1);
        drain();
        chk("t4_windows", 80'(n_win), 80'(4));
        chk("t4_lasts", 80'(n_last), 80'(1));

        // Reset after pixel 9, then a full frame without in_sof.
        start_test(2'd0, 4, 4, 0);
        for (int p = 0; p < 10; p++) send_pixel(8'(p + 100), p == 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_out_valid", 80'(ov_s), 80'(0));
        chk("t5_reset_window", 80'(win_s), 80'(0));
        chk("t5_reset_in_ready", 80'(ir_s), 80'(1));
        q.delete();
        mrow = 0;
        mcol = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 16; p++) send_pixel(8'($urandom), 1'b0, 1'b0);
        drain();
        chk("t5_windows", 80'(n_win), 80'(4));

        // Minimum 3x3 frame: one window holding the whole image.
        start_test(2'd2, 3, 3, 0);
        for (int p = 1; p <= 9; p++) send_pixel(8'(p), p == 1, 1'b0);
        drain();
        chk("t6_windows", 80'(n_win), 80'(1));
        chk("t6_window", 80'(last_win), 80'(72'h090807060504030201));
        chk("t6_last_flag", 80'(last_flag), 80'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
